// File: rtl/camera_frame_packer.sv
// Collects one raster-order RGB frame from a valid/ready pixel stream into a flat image register,
// launches the feature extractor with a one-cycle start pulse and waits for its done (or a timeout).
module camera_frame_packer #(
    parameter int unsigned H            = 16,
    parameter int unsigned W            = 8,
    parameter int unsigned DONE_TIMEOUT = 32768
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [23:0]         pix_data,
    input  logic                pix_sof,
    input  logic                pix_eof,
    output logic [H*W*24-1:0]   frame_image,
    output logic                start,
    input  logic                fe_done,
    output logic [15:0]         frame_cnt,
    output logic [7:0]          drop_cnt,
    output logic                err_timeout
);

    localparam int unsigned NPIX = H * W;
    localparam int unsigned PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned CW   = $clog2(DONE_TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   pix_idx;
    logic [CW-1:0]   wait_cnt;

    logic            beat;
    logic            restart;
    logic            last_beat;
    logic            short_eof;
    logic            drop_evt;
    logic            timeout;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat classification; sof wins over eof, and the final pixel completes regardless of eof
    always_comb begin
        beat      = pix_valid & pix_ready;
        restart   = 1'b0;
        last_beat = 1'b0;
        short_eof = 1'b0;
        drop_evt  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                drop_evt = beat & ~pix_sof;
            end
            FILL: begin
                restart   = beat & pix_sof;
                last_beat = beat & ~pix_sof & (pix_idx == LAST_PIX);
                short_eof = beat & ~pix_sof & pix_eof & (pix_idx != LAST_PIX);
                drop_evt  = restart | short_eof;
            end
            WAIT_DONE: begin
                timeout = ~fe_done & (wait_cnt == LAST_WAIT);
            end
            default: ;
        endcase
        wr_en  = beat & (pix_sof | (state == FILL));
        wr_idx = pix_sof ? '0 : pix_idx;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (beat && pix_sof) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (last_beat) begin
                    state_nxt = ISSUE;
                end else if (short_eof) begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (fe_done || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; ready is forced low while reset is held
    always_comb begin
        pix_ready = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE:      pix_ready = ~rst;
            FILL:      pix_ready = ~rst;
            ISSUE:     start     = 1'b1;
            default: ;
        endcase
    end

    // Datapath: pixel index, image store, counters and timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx     <= '0;
            wait_cnt    <= '0;
            frame_image <= '0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout;
            if (state == ISSUE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop_evt && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            wait_cnt <= (state == WAIT_DONE) ? wait_cnt + CW'(1) : '0;
            if (wr_en) begin
                frame_image[24*wr_idx +: 24] <= pix_data;
                pix_idx                      <= wr_idx + PW'(1);
            end
            if (last_beat || short_eof) begin
                pix_idx <= '0;
            end
        end
    end

endmodule
